// File: rtl/rvvi_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : rvvi_sched_pkg
//  Purpose : Shared types for the RVVI trace scheduler. These are the
//            scheduler FSM states and the error codes it reports.
//  Revision: 1.0 - initial release
// ============================================================================
package rvvi_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_GAP   = 2'd1,
        ERR_STALE = 2'd2,
        ERR_DUP   = 2'd3
    } err_t;

endpackage
`default_nettype wire

// File: rtl/rvvi_trace_hold.sv
`default_nettype none
// ============================================================================
//  Module  : rvvi_trace_hold
//  Purpose : One-entry holding register for a single trace stream.
//  Ports   : clk, reset_n       - clock, async active-low reset
//            flush_i            - drop any held record
//            enable_i           - scheduler is accepting records
//            valid_i / ready_o  - upstream handshake
//            order_i / rec_i    - upstream record
//            drain_i            - scheduler consumed the held record
//            hold_v_o, hold_order_o, hold_rec_o - held record
//  Revision: 1.0 - initial release
// ============================================================================
module rvvi_trace_hold #(
    parameter int ORDER_W = 64,
    parameter int RECW    = 256
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush_i,
    input  logic               enable_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [ORDER_W-1:0] order_i,
    input  logic [RECW-1:0]    rec_i,
    input  logic               drain_i,
    output logic               hold_v_o,
    output logic [ORDER_W-1:0] hold_order_o,
    output logic [RECW-1:0]    hold_rec_o
);

    logic               v_q, v_d;
    logic [ORDER_W-1:0] order_q;
    logic [RECW-1:0]    rec_q;
    logic               w_load;

    // Ready only while empty. A drained entry therefore refills no earlier
    // than the following cycle.
    assign ready_o = ~v_q & enable_i;
    assign w_load  = valid_i & ready_o;

    always_comb begin
        v_d = v_q;
        if (flush_i)      v_d = 1'b0;
        else if (w_load)  v_d = 1'b1;
        else if (drain_i) v_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q     <= 1'b0;
            order_q <= '0;
            rec_q   <= '0;
        end else begin
            v_q <= v_d;
            if (w_load && !flush_i) begin
                order_q <= order_i;
                rec_q   <= rec_i;
            end
        end
    end

    assign hold_v_o     = v_q;
    assign hold_order_o = order_q;
    assign hold_rec_o   = rec_q;

endmodule
`default_nettype wire

// File: rtl/rvvi_trace_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : rvvi_trace_scheduler
//  Purpose : Merges NREQ trace streams onto one RVVI retire slot in strict
//            ORDER sequence. Reports gaps, stale records and duplicates.
//            Signals end-of-trace when every stream is exhausted.
//  Ports   : clk, reset_n                      - clock, async active-low reset
//            start, clear, start_order         - control
//            req_valid/ready/order/rec/done    - per-stream inputs (packed)
//            out_valid/ready/order/rec/src     - retired record
//            busy, done, err, err_code         - status
//  Revision: 1.0 - initial release
// ============================================================================
module rvvi_trace_scheduler
    import rvvi_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ORDER_W = 64,
    parameter int RECW    = 256,
    parameter int TIMEOUT = 1024,
    localparam int SRC_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    clear,
    input  logic [ORDER_W-1:0]      start_order,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*ORDER_W-1:0] req_order,
    input  logic [NREQ*RECW-1:0]    req_rec,
    input  logic [NREQ-1:0]         req_done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ORDER_W-1:0]      out_order,
    output logic [RECW-1:0]         out_rec,
    output logic [SRC_W-1:0]        out_src,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [1:0]              err_code
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t             state_q, state_d;
    err_t               err_code_q, err_code_d;
    logic [ORDER_W-1:0] exp_order_q, exp_order_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               out_valid_q, out_valid_d;
    logic [ORDER_W-1:0] out_order_q, out_order_d;
    logic [RECW-1:0]    out_rec_q, out_rec_d;
    logic [SRC_W-1:0]   out_src_q, out_src_d;
    // Holds req_ready low for the first cycle after reset so every output is 0 in reset.
    logic               rdy_en_q;

    logic [NREQ-1:0]    w_hold_v, w_match, w_stale, w_drain;
    logic [ORDER_W-1:0] w_hold_order [NREQ];
    logic [RECW-1:0]    w_hold_rec   [NREQ];
    logic [SRC_W-1:0]   w_sel;
    logic               w_run, w_idle, w_dup, w_err_stale, w_emit;
    logic               w_stall, w_wd_cnt, w_err_gap, w_start, w_all_done;

    assign w_run   = (state_q == RUN);
    assign w_idle  = (state_q == IDLE);
    assign w_start = w_idle & start & ~clear;

    for (genvar i = 0; i < NREQ; i++) begin : g_hold
        logic [ORDER_W-1:0] w_diff;

        rvvi_trace_hold #(.ORDER_W(ORDER_W), .RECW(RECW)) u_hold (
            .clk         (clk),
            .reset_n     (reset_n),
            .flush_i     (clear),
            .enable_i    (rdy_en_q & (w_idle | w_run)),
            .valid_i     (req_valid[i]),
            .ready_o     (req_ready[i]),
            .order_i     (req_order[i*ORDER_W +: ORDER_W]),
            .rec_i       (req_rec[i*RECW +: RECW]),
            .drain_i     (w_drain[i]),
            .hold_v_o    (w_hold_v[i]),
            .hold_order_o(w_hold_order[i]),
            .hold_rec_o  (w_hold_rec[i])
        );

        // A zero distance is a match. A negative distance (MSB set) means
        // the record is behind the expected ORDER, which makes it stale.
        assign w_diff     = w_hold_order[i] - exp_order_q;
        assign w_match[i] = w_hold_v[i] & (w_diff == '0);
        assign w_stale[i] = w_hold_v[i] & w_diff[ORDER_W-1];
        assign w_drain[i] = w_emit & (w_sel == SRC_W'(i));
    end

    // Lowest-index matching stream
    always_comb begin
        w_sel = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_match[i]) w_sel = SRC_W'(i);
        end
    end

    // This is true when more than one bit of w_match is set.
    assign w_dup       = w_run & ((w_match & (w_match - 1'b1)) != '0);
    assign w_err_stale = w_run & (|w_stale);
    assign w_stall     = out_valid_q & ~out_ready;
    assign w_emit      = w_run & (|w_match) & ~w_stall & ~w_dup & ~w_err_stale;
    assign w_wd_cnt    = w_run & (|w_hold_v) & ~w_emit & ~w_stall;
    assign w_err_gap   = w_wd_cnt & (wdog_q == WD_W'(TIMEOUT - 1));
    assign w_all_done  = (&req_done) & ~(|w_hold_v) & ~out_valid_q;

    // FSM next state and error code
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        if (clear) begin
            state_d    = IDLE;
            err_code_d = ERR_NONE;
        end else begin
            case (state_q)
                IDLE: if (start) state_d = RUN;
                RUN: begin
                    if (w_dup) begin
                        state_d    = ERR;
                        err_code_d = ERR_DUP;
                    end else if (w_err_stale) begin
                        state_d    = ERR;
                        err_code_d = ERR_STALE;
                    end else if (w_err_gap) begin
                        state_d    = ERR;
                        err_code_d = ERR_GAP;
                    end else if (w_all_done) begin
                        state_d    = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Expected ORDER, watchdog and output slot
    always_comb begin
        exp_order_d = exp_order_q;
        wdog_d      = wdog_q;
        out_valid_d = out_valid_q;
        out_order_d = out_order_q;
        out_rec_d   = out_rec_q;
        out_src_d   = out_src_q;
        if (clear) begin
            exp_order_d = '0;
            wdog_d      = '0;
            out_valid_d = 1'b0;
            out_order_d = '0;
            out_rec_d   = '0;
            out_src_d   = '0;
        end else begin
            if (w_start) begin
                exp_order_d = start_order;
                wdog_d      = '0;
            end else if (w_emit) begin
                exp_order_d = exp_order_q + 1'b1;
                wdog_d      = '0;
            end else if (w_wd_cnt) begin
                wdog_d      = wdog_q + 1'b1;
            end

            if (w_emit) begin
                out_valid_d = 1'b1;
                out_order_d = w_hold_order[w_sel];
                out_rec_d   = w_hold_rec[w_sel];
                out_src_d   = w_sel;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            err_code_q  <= ERR_NONE;
            exp_order_q <= '0;
            wdog_q      <= '0;
            out_valid_q <= 1'b0;
            out_order_q <= '0;
            out_rec_q   <= '0;
            out_src_q   <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_code_q  <= err_code_d;
            exp_order_q <= exp_order_d;
            wdog_q      <= wdog_d;
            out_valid_q <= out_valid_d;
            out_order_q <= out_order_d;
            out_rec_q   <= out_rec_d;
            out_src_q   <= out_src_d;
            rdy_en_q    <= 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_order = out_order_q;
    assign out_rec   = out_rec_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign err       = (state_q == ERR);
    assign err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_rvvi_trace_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : tb_rvvi_trace_scheduler
//  Purpose : Directed self-checking bench for rvvi_trace_scheduler.
//            It uses two streams, 64-bit ORDER, a 32-bit record and a short
//            watchdog.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_rvvi_trace_scheduler;

    localparam int NREQ    = 2;
    localparam int ORDER_W = 64;
    localparam int RECW    = 32;
    localparam int TIMEOUT = 16;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    start = 1'b0;
    logic                    clear = 1'b0;
    logic [ORDER_W-1:0]      start_order = '0;
    logic [NREQ-1:0]         req_valid = '0;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*ORDER_W-1:0] req_order = '0;
    logic [NREQ*RECW-1:0]    req_rec = '0;
    logic [NREQ-1:0]         req_done = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [ORDER_W-1:0]      out_order;
    logic [RECW-1:0]         out_rec;
    logic [0:0]              out_src;
    logic                    busy, done, err;
    logic [1:0]              err_code;

    int errors = 0;
    int checks = 0;

    logic [63:0] q_order[$];
    logic        q_src[$];
    logic [31:0] q_rec[$];

    always #5 clk = ~clk;

    rvvi_trace_scheduler #(
        .NREQ(NREQ), .ORDER_W(ORDER_W), .RECW(RECW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .clear(clear),
        .start_order(start_order), .req_valid(req_valid), .req_ready(req_ready),
        .req_order(req_order), .req_rec(req_rec), .req_done(req_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
        .out_rec(out_rec), .out_src(out_src), .busy(busy), .done(done),
        .err(err), .err_code(err_code)
    );

    // Records every completed output handshake. Inputs change only just after posedge.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            q_order.push_back(out_order);
            q_src.push_back(out_src[0]);
            q_rec.push_back(out_rec);
        end
    end

    function automatic logic [31:0] mk_rec(input logic [63:0] o);
        return o[31:0] ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int s, input logic [63:0] o);
        int t = 0;
        while (req_ready[s] !== 1'b1 && t < 100) begin
            tick();
            t++;
        end
        check("push_ready", {63'd0, req_ready[s]}, 64'd1);
        req_valid[s] = 1'b1;
        req_order[s*ORDER_W +: ORDER_W] = o;
        req_rec[s*RECW +: RECW] = mk_rec(o);
        tick();
        req_valid[s] = 1'b0;
    endtask

    task automatic wait_q(input int n);
        int t = 0;
        while (q_order.size() < n && t < 200) begin
            tick();
            t++;
        end
        check("qlen", 64'(q_order.size()), 64'(n));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        q_order.delete();
        q_src.delete();
        q_rec.delete();
    endtask

    task automatic do_start(input logic [63:0] o);
        start_order = o;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_order"}, out_order, 64'd0);
        check({tag, "_rec"}, {32'd0, out_rec}, 64'd0);
        check({tag, "_src"}, {63'd0, out_src}, 64'd0);
        check({tag, "_ready"}, {62'd0, req_ready}, 64'd0);
        check({tag, "_status"}, {60'd0, busy, done, err, 1'b0}, 64'd0);
        check({tag, "_code"}, {62'd0, err_code}, 64'd0);
    endtask

    initial begin
        int t;
        int n;
        logic [63:0] wo [4];

        // Reset values
        #2;
        check_all_zero("reset");
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("idle_ready", {62'd0, req_ready}, 64'd3);

        // Interleaved streams 0,2,4 / 1,3,5
        push(0, 64'd0);
        push(1, 64'd1);
        do_start(64'd0);
        check("run_busy", {63'd0, busy}, 64'd1);
        push(0, 64'd2);
        push(1, 64'd3);
        push(0, 64'd4);
        push(1, 64'd5);
        req_done = 2'b11;
        wait_q(6);
        for (int k = 0; k < 6 && k < q_order.size(); k++) begin
            check("seq_order", q_order[k], 64'(k));
            check("seq_src", {63'd0, q_src[k]}, 64'(k % 2));
            check("seq_rec", {32'd0, q_rec[k]}, {32'd0, mk_rec(64'(k))});
        end
        t = 0;
        while (!done && t < 20) begin
            tick();
            t++;
        end
        check("seq_done", {63'd0, done}, 64'd1);
        check("seq_status", {61'd0, busy, err, out_valid}, 64'd0);
        check("seq_code", {62'd0, err_code}, 64'd0);
        check("done_ready", {62'd0, req_ready}, 64'd0);

        // Output stall: the record must stay stable, and the watchdog must not count while stalled.
        do_clear();
        req_done = 2'b00;
        out_ready = 1'b0;
        push(0, 64'd10);
        push(1, 64'd11);
        do_start(64'd10);
        tick();
        for (int k = 0; k < 20; k++) begin
            check("stall_valid", {63'd0, out_valid}, 64'd1);
            check("stall_order", out_order, 64'd10);
            if (k < 5) begin
                check("stall_src", {63'd0, out_src}, 64'd0);
                check("stall_rec", {32'd0, out_rec}, {32'd0, mk_rec(64'd10)});
            end
            tick();
        end
        check("stall_err", {63'd0, err}, 64'd0);
        out_ready = 1'b1;
        push(0, 64'd12);
        wait_q(3);
        for (int k = 0; k < 3 && k < q_order.size(); k++)
            check("stall_seq", q_order[k], 64'(10 + k));

        // ORDER wrap from all-ones to zero
        do_clear();
        wo[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        wo[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        wo[2] = 64'd0;
        wo[3] = 64'd1;
        push(0, wo[0]);
        push(1, wo[1]);
        do_start(wo[0]);
        push(0, wo[2]);
        push(1, wo[3]);
        wait_q(4);
        for (int k = 0; k < 4 && k < q_order.size(); k++) begin
            check("wrap_order", q_order[k], wo[k]);
            check("wrap_rec", {32'd0, q_rec[k]}, {32'd0, mk_rec(wo[k])});
        end
        check("wrap_err", {63'd0, err}, 64'd0);
        check("wrap_busy", {63'd0, busy}, 64'd1);

        // Gap: 5 emitted, 6 never arrives
        do_clear();
        push(0, 64'd5);
        push(1, 64'd7);
        do_start(64'd5);
        t = 0;
        while (!out_valid && t < 10) begin
            tick();
            t++;
        end
        check("gap_first", out_order, 64'd5);
        n = 0;
        while (!err && n < 100) begin
            tick();
            n++;
        end
        check("gap_latency", 64'(n), 64'(TIMEOUT));
        check("gap_code", {62'd0, err_code}, 64'd1);
        check("gap_outv", {63'd0, out_valid}, 64'd0);
        check("gap_ready", {62'd0, req_ready}, 64'd0);
        check("gap_busy", {63'd0, busy}, 64'd0);

        // Duplicate order 3 on both streams
        do_clear();
        push(0, 64'd3);
        push(1, 64'd3);
        do_start(64'd3);
        tick();
        check("dup_err", {63'd0, err}, 64'd1);
        check("dup_code", {62'd0, err_code}, 64'd3);
        check("dup_outv", {63'd0, out_valid}, 64'd0);
        tick();
        check("dup_outv2", {63'd0, out_valid}, 64'd0);
        check("dup_none", 64'(q_order.size()), 64'd0);

        // Clear while running with full holds
        do_clear();
        check("clr_code", {62'd0, err_code}, 64'd0);
        push(0, 64'd8);
        push(1, 64'd9);
        check("full_ready", {62'd0, req_ready}, 64'd0);
        do_start(64'd0);
        check("full_busy", {63'd0, busy}, 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_busy", {63'd0, busy}, 64'd0);
        check("clr_ready", {62'd0, req_ready}, 64'd3);
        check("clr_flags", {61'd0, done, err, out_valid}, 64'd0);

        // Asynchronous reset mid-run with a stalled output record
        push(0, 64'h20);
        push(1, 64'h21);
        out_ready = 1'b0;
        do_start(64'h20);
        tick();
        check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        check("pre_rst_order", out_order, 64'h20);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
